// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit computer control path:
//   - opcode encodings (IR upper nibble)
//   - control-word bit positions (bit 15 = HLT ... bit 0 = FI)
//   - T-state encodings T0..T4
//   - last active step per opcode, used for early instruction termination
//   - bus-driver helpers used by the control path and its checker
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int CTRL_W = 16;
  localparam int T_W    = 3;
  localparam int OP_W   = 4;

  // Opcode encodings; 1001..1101 are undefined and execute as NOP.
  localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_STA = 4'b0100;
  localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
  localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
  localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // Control-word bit positions.
  localparam int CTRL_HLT = 15;  // halt clock
  localparam int CTRL_MI  = 14;  // memory address register in
  localparam int CTRL_RI  = 13;  // RAM in
  localparam int CTRL_RO  = 12;  // RAM out (bus driver)
  localparam int CTRL_IO  = 11;  // instruction register out (bus driver)
  localparam int CTRL_II  = 10;  // instruction register in
  localparam int CTRL_AI  = 9;   // A register in
  localparam int CTRL_AO  = 8;   // A register out (bus driver)
  localparam int CTRL_EO  = 7;   // ALU out (bus driver)
  localparam int CTRL_SU  = 6;   // ALU subtract
  localparam int CTRL_BI  = 5;   // B register in
  localparam int CTRL_OI  = 4;   // output register in
  localparam int CTRL_CE  = 3;   // program counter enable
  localparam int CTRL_CO  = 2;   // program counter out (bus driver)
  localparam int CTRL_J   = 1;   // program counter load (jump)
  localparam int CTRL_FI  = 0;   // flags register in

  // T-state encodings.
  localparam logic [T_W-1:0] T0 = 3'd0;
  localparam logic [T_W-1:0] T1 = 3'd1;
  localparam logic [T_W-1:0] T2 = 3'd2;
  localparam logic [T_W-1:0] T3 = 3'd3;
  localparam logic [T_W-1:0] T4 = 3'd4;

  // Output bundle of the control ROM.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              last_step;
  } rom_word_t;

  // Last active T-state of each instruction. Conditional jumps end at T2
  // whether or not the branch is taken.
  function automatic logic [T_W-1:0] last_step_of(input logic [OP_W-1:0] op);
    logic [T_W-1:0] last;
    case (op)
      OP_LDA:  last = T3;
      OP_STA:  last = T3;
      OP_ADD:  last = T4;
      OP_SUB:  last = T4;
      OP_NOP:  last = T2;
      OP_LDI:  last = T2;
      OP_JMP:  last = T2;
      OP_JC:   last = T2;
      OP_JZ:   last = T2;
      OP_OUT:  last = T2;
      OP_HLT:  last = T2;
      default: last = T2;
    endcase
    return last;
  endfunction

  // Gather the bits that place a value on the shared bus.
  function automatic logic [4:0] bus_drivers(input logic [CTRL_W-1:0] c);
    return {c[CTRL_CO], c[CTRL_RO], c[CTRL_IO], c[CTRL_AO], c[CTRL_EO]};
  endfunction

  // True when zero or one bus driver is enabled.
  function automatic logic bus_exclusive(input logic [CTRL_W-1:0] c);
    logic [4:0] d;
    d = bus_drivers(c);
    return ((d & (d - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/control_rom.sv
// -----------------------------------------------------------------------------
// control_rom
// Purely combinational microcode: maps the current T-state, opcode and latched
// ALU flags to the control word for that step, plus a flag marking the
// instruction's last active step.
// Ports:
//   t_state    in  3   current step
//   opcode     in  4   IR upper nibble
//   carry_flag in  1   latched carry (JC condition)
//   zero_flag  in  1   latched zero  (JZ condition)
//   ctrl       out 16  control word for this step (ungated)
//   last_step  out 1   this step is the instruction's last active step
// -----------------------------------------------------------------------------
module control_rom
  import cpu_pkg::*;
(
  input  logic [T_W-1:0]    t_state,
  input  logic [OP_W-1:0]   opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last_step
);

  rom_word_t word;

  // Decode one step: fetch steps are opcode independent, execute steps decode IR.
  always_comb begin
    word.ctrl      = 16'h0000;
    word.last_step = 1'b0;
    case (t_state)
      T0: begin
        word.ctrl[CTRL_CO] = 1'b1;
        word.ctrl[CTRL_MI] = 1'b1;
      end
      T1: begin
        word.ctrl[CTRL_RO] = 1'b1;
        word.ctrl[CTRL_II] = 1'b1;
        word.ctrl[CTRL_CE] = 1'b1;
      end
      T2, T3, T4: begin
        word.last_step = (t_state == last_step_of(opcode));
        case (opcode)
          OP_LDA, OP_STA: begin
            case (t_state)
              T2: begin
                word.ctrl[CTRL_IO] = 1'b1;
                word.ctrl[CTRL_MI] = 1'b1;
              end
              T3: begin
                if (opcode == OP_LDA) begin
                  word.ctrl[CTRL_RO] = 1'b1;
                  word.ctrl[CTRL_AI] = 1'b1;
                end else begin
                  word.ctrl[CTRL_AO] = 1'b1;
                  word.ctrl[CTRL_RI] = 1'b1;
                end
              end
              default: word.ctrl = 16'h0000;
            endcase
          end
          OP_ADD, OP_SUB: begin
            case (t_state)
              T2: begin
                word.ctrl[CTRL_IO] = 1'b1;
                word.ctrl[CTRL_MI] = 1'b1;
              end
              T3: begin
                word.ctrl[CTRL_RO] = 1'b1;
                word.ctrl[CTRL_BI] = 1'b1;
              end
              T4: begin
                word.ctrl[CTRL_EO] = 1'b1;
                word.ctrl[CTRL_AI] = 1'b1;
                word.ctrl[CTRL_FI] = 1'b1;
                word.ctrl[CTRL_SU] = (opcode == OP_SUB);
              end
              default: word.ctrl = 16'h0000;
            endcase
          end
          OP_LDI: begin
            if (t_state == T2) begin
              word.ctrl[CTRL_IO] = 1'b1;
              word.ctrl[CTRL_AI] = 1'b1;
            end else begin
              word.ctrl = 16'h0000;
            end
          end
          OP_JMP, OP_JC, OP_JZ: begin
            // The operand is always driven; only the PC load is conditional.
            if (t_state == T2) begin
              word.ctrl[CTRL_IO] = 1'b1;
              case (opcode)
                OP_JMP:  word.ctrl[CTRL_J] = 1'b1;
                OP_JC:   word.ctrl[CTRL_J] = carry_flag;
                OP_JZ:   word.ctrl[CTRL_J] = zero_flag;
                default: word.ctrl[CTRL_J] = 1'b0;
              endcase
            end else begin
              word.ctrl = 16'h0000;
            end
          end
          OP_OUT: begin
            if (t_state == T2) begin
              word.ctrl[CTRL_AO] = 1'b1;
              word.ctrl[CTRL_OI] = 1'b1;
            end else begin
              word.ctrl = 16'h0000;
            end
          end
          OP_HLT: begin
            if (t_state == T2) begin
              word.ctrl[CTRL_HLT] = 1'b1;
            end else begin
              word.ctrl = 16'h0000;
            end
          end
          OP_NOP:  word.ctrl = 16'h0000;
          default: word.ctrl = 16'h0000;
        endcase
      end
      default: begin
        // Unreachable encodings 5..7: emit nothing and force a return to T0.
        word.ctrl      = 16'h0000;
        word.last_step = 1'b1;
      end
    endcase
  end

  assign ctrl      = word.ctrl;
  assign last_step = word.last_step;

endmodule

// File: rtl/control_sequencer_checker.sv
// -----------------------------------------------------------------------------
// control_sequencer_checker
// Simulation-time property checks for control_sequencer outputs.
// Ports:
//   clk      in  1   system clock
//   rst      in  1   synchronous active-high reset (checks suspended)
//   ctrl     in  16  control word under check
//   t_state  in  3   step counter under check
// -----------------------------------------------------------------------------
module control_sequencer_checker
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [T_W-1:0]    t_state
);

  // At most one bus driver per step, and the counter never leaves T0..T4.
  always @(posedge clk) begin
    if (!rst) begin
      assert (bus_exclusive(ctrl));
      assert (t_state <= T4);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Instruction-cycle controller for the 8-bit computer. Steps the T-state
// counter, tracks the halted condition and gates the microcode control word.
// Parameters:
//   EARLY_END  1 = return to T0 after the instruction's last active step,
//              0 = always run T0..NUM_STEPS-1
//   NUM_STEPS  T-states per instruction when EARLY_END=0 (5 for this ISA)
// Ports:
//   clk        in  1   system clock, rising edge
//   rst        in  1   synchronous active-high reset
//   step_en    in  1   advance enable (single-step / run gating)
//   opcode     in  4   IR upper nibble
//   carry_flag in  1   latched ALU carry
//   zero_flag  in  1   latched ALU zero
//   ctrl       out 16  control word HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
//   t_state    out 3   current step 0..4
//   halted     out 1   sequencer stopped by HLT
// -----------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
#(
  parameter bit EARLY_END = 1'b1,
  parameter int NUM_STEPS = 5
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step_en,
  input  logic [OP_W-1:0]   opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CTRL_W-1:0] ctrl,
  output logic [T_W-1:0]    t_state,
  output logic              halted
);

  localparam logic [T_W-1:0] LAST_T = T_W'(NUM_STEPS - 1);
  localparam logic [CTRL_W-1:0] HLT_ONLY = 16'h8000;

  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last;
  logic [T_W-1:0]    next_t;
  logic              next_halted;

  control_rom u_rom (
    .t_state    (t_state),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .ctrl       (rom_ctrl),
    .last_step  (rom_last)
  );

  // Next-state selection: hold when halted or not enabled, else advance/end.
  always_comb begin
    next_t      = t_state;
    next_halted = halted;
    if (halted) begin
      next_t      = t_state;
      next_halted = 1'b1;
    end else if (!step_en) begin
      next_t      = t_state;
      next_halted = 1'b0;
    end else if (rom_ctrl[CTRL_HLT]) begin
      next_t      = T0;
      next_halted = 1'b1;
    end else if (EARLY_END && rom_last) begin
      next_t      = T0;
      next_halted = 1'b0;
    end else if (t_state >= LAST_T) begin
      // Also recovers from any encoding above the last step.
      next_t      = T0;
      next_halted = 1'b0;
    end else begin
      next_t      = t_state + 3'd1;
      next_halted = 1'b0;
    end
  end

  // Step counter and halt flag; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_state <= T0;
      halted  <= 1'b0;
    end else begin
      t_state <= next_t;
      halted  <= next_halted;
    end
  end

  // Output gating: a held step emits nothing, so CE fires once per real step.
  always_comb begin
    ctrl = 16'h0000;
    if (rst) begin
      ctrl = 16'h0000;
    end else if (halted) begin
      ctrl = HLT_ONLY;
    end else if (!step_en) begin
      ctrl = 16'h0000;
    end else begin
      ctrl = rom_ctrl;
    end
  end

endmodule
